sdram_rd_chk: RTL and testbench
===============================

# sdram_rd_chk

Read-back checker for the SDRAM edge test path. Consumes the data beats returned from SDRAM reads and compares each against the arithmetic test pattern the write-side generator produced: start value 0, +STEP per valid beat, modulo 2^DATA_W. It reports per-beat mismatches, a saturating error count, the first failing beat, and a burst-complete pulse. It sits between the SDRAM controller read-data port and the board status/LED logic.

## Interface
- DATA_W, 8: data beat width.
- STEP, 2: pattern increment per beat.
- BURST_LEN, 100: beats checked per run; legal range 1..2^16-1.
- ERR_W, 16: error-counter width.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; arms a check run.
- din_vld  input  1  read-data beat valid.
- din  input  DATA_W  read-data beat.
- busy  output  1  high while a run is in progress.
- err_pls  output  1  one-cycle pulse per mismatching beat.
- err_flag  output  1  sticky: any mismatch since last start.
- err_cnt  output  ERR_W  mismatch count, saturating at all-ones.
- first_err_idx  output  16  beat index of first mismatch.
- first_err_dat  output  DATA_W  received value of first mismatch.
- done  output  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, CHECK, DONE.
- IDLE: din_vld ignored. start -> CHECK; expected value exp <= 0, beat index idx <= 0, err_flag/err_cnt/first_err_* cleared.
- CHECK: busy=1. On each din_vld, compare din with exp; idx += 1; exp <= exp + STEP, truncated to DATA_W, so it wraps naturally, e.g. 254 -> 0 for DATA_W=8, STEP=2. The beat with idx = BURST_LEN-1 -> DONE.
- Mismatch: err_pls=1; err_flag=1; err_cnt += 1 unless already all-ones. If it is the first mismatch of the run, capture idx into first_err_idx and din into first_err_dat.
- DONE: done=1 for exactly one cycle -> IDLE. Result outputs hold until the next start.
- start during CHECK or DONE is ignored. start and din_vld in the same IDLE cycle: that beat is not checked; checking begins the following cycle.
- No beats may be dropped: din_vld low simply stalls the run, with no timeout.

## Timing
- Reset values: busy=0, err_pls=0, err_flag=0, err_cnt=0, first_err_idx=0, first_err_dat=0, done=0; state IDLE.
- All outputs registered. Latency from a din_vld beat to the corresponding err_pls/err_cnt update is 1 cycle.
- done asserts 1 cycle after the last beat's clock edge, concurrent with that beat's err_pls if it mismatches.
- busy rises 1 cycle after start and falls when done asserts.
- Back-to-back din_vld at full rate must be supported.
- Reset mid-run aborts immediately to reset values. No done pulse is produced.

## Configuration
- SDRAM_RD_CHK_RESYNC_EN defined: on a mismatch, the next exp is din + STEP instead of exp + STEP. A single dropped or duplicated beat then produces one error instead of a cascade.
- Not defined: exp advances independently of din. Every beat after a slip mismatches.

## Structure
- Package sdram_rd_chk_pkg holds:
  - the state enum (IDLE, CHECK, DONE);
  - default STEP and DATA_W constants, shared with the write-side generator;
  - a next_pattern(value, step) function.
- One sub-module, sdram_rd_chk_pat, is natural: the expected-value register with load-zero, advance and (under the macro) resync controls. The FSM, counters and capture logic stay in the top.

## Test plan
- Clean run: DATA_W=8, STEP=2, BURST_LEN=100; start, then 100 beats 0,2,...,198 -> err_cnt=0, err_flag=0, done pulses once, 1 cycle after beat 99.
- Wrap: BURST_LEN=200; beats 0..254 then 0..142 step 2 -> err_cnt=0. Confirms exp wraps 254->0.
- Single corruption: beat 5 sent as 0xFF instead of 10 -> err_pls on the cycle after beat 5, err_cnt=1, first_err_idx=5, first_err_dat=0xFF.
- Dropped beat: skip value 20 (beat 10 onward sends 22,24,...), BURST_LEN=100 -> without macro err_cnt=90; with SDRAM_RD_CHK_RESYNC_EN err_cnt=1.
- Gapped valid plus ignored inputs:
  - din_vld toggling 1/0 -> same results as the back-to-back run.
  - Beats in IDLE do not change err_cnt.
  - A second start mid-run is ignored.
- Reset mid-run: rst_n low after beat 40 -> all outputs 0 immediately, no done. A new start then runs cleanly with err_cnt=0.

Source files
------------

// File: rtl/sdram_rd_chk_pkg.sv
// sdram_rd_chk_pkg
//   Shared definitions for the SDRAM read-back checker and the write-side
//   pattern generator: FSM state type, default pattern constants and the
//   pattern advance function.
package sdram_rd_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_STEP   = 2;

    // Next pattern value; the caller truncates to its data width, which
    // gives the modulo-2^DATA_W wrap.
    function automatic logic [31:0] next_pattern(input logic [31:0] value,
                                                 input logic [31:0] step);
        return value + step;
    endfunction

endpackage

// File: rtl/sdram_rd_chk_pat.sv
// sdram_rd_chk_pat
//   Expected-value register for the read-back checker.
//   Ports:
//     clk, rst_n   clock, async active-low reset
//     i_load       clear expected value to 0 (start of a run)
//     i_adv        advance by STEP (one checked beat)
//     i_resync     current beat mismatched; used only when
//                  SDRAM_RD_CHK_RESYNC_EN is defined
//     i_din        received beat (resync base)
//     o_exp        current expected value
//   Macro SDRAM_RD_CHK_RESYNC_EN: on a mismatch the next expected value is
//   derived from the received data, so a slipped beat costs one error.
module sdram_rd_chk_pat
    import sdram_rd_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STEP   = DEF_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic              i_resync,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_exp
);

    logic [DATA_W-1:0] r_exp;
    logic [DATA_W-1:0] w_base;
    logic [31:0]       w_nxt;

`ifdef SDRAM_RD_CHK_RESYNC_EN
    assign w_base = i_resync ? i_din : r_exp;
`else
    logic w_unused_resync;
    assign w_unused_resync = i_resync;
    assign w_base          = r_exp;
`endif

    assign w_nxt = next_pattern(32'(w_base), 32'(STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_exp <= '0;
        else if (i_load) r_exp <= '0;
        else if (i_adv)  r_exp <= w_nxt[DATA_W-1:0];
    end

    assign o_exp = r_exp;

endmodule

// File: rtl/sdram_rd_chk.sv
// sdram_rd_chk
//   Read-back checker: compares SDRAM read beats against the arithmetic
//   test pattern (0, +STEP, ... mod 2^DATA_W) and reports mismatches.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     start               one-cycle pulse, arms a run (IDLE only)
//     din_vld, din        read-data beat
//     busy                run in progress
//     err_pls             one cycle per mismatching beat
//     err_flag            sticky mismatch since last start
//     err_cnt             saturating mismatch count
//     first_err_idx/_dat  beat index / data of the first mismatch
//     done                one-cycle pulse at run completion
//   Macro SDRAM_RD_CHK_RESYNC_EN: resync expected value on mismatch.
module sdram_rd_chk
    import sdram_rd_chk_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STEP      = DEF_STEP,
    parameter int BURST_LEN = 100,
    parameter int ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              err_pls,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_dat,
    output logic              done
);

    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    state_t            r_state, w_nstate;
    logic [15:0]       r_idx;
    logic              r_busy, r_err_pls, r_err_flag, r_done;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [15:0]       r_first_idx;
    logic [DATA_W-1:0] r_first_dat;

    logic              w_arm, w_beat, w_mis, w_last;
    logic [DATA_W-1:0] w_exp;

    assign w_arm  = (r_state == IDLE) && start;
    assign w_beat = (r_state == CHECK) && din_vld;
    assign w_mis  = w_beat && (din != w_exp);
    assign w_last = (r_idx == LAST_IDX);

    sdram_rd_chk_pat #(.DATA_W(DATA_W), .STEP(STEP)) u_pat (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_arm),
        .i_adv    (w_beat),
        .i_resync (w_mis),
        .i_din    (din),
        .o_exp    (w_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            IDLE:    if (start) w_nstate = CHECK;
            CHECK:   if (w_beat && w_last) w_nstate = DONE;
            DONE:    w_nstate = IDLE;
            default: w_nstate = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so busy/done line
    // up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_pls   <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_cnt   <= '0;
            r_idx       <= '0;
            r_first_idx <= '0;
            r_first_dat <= '0;
        end else begin
            r_busy    <= (w_nstate == CHECK);
            r_done    <= (w_nstate == DONE);
            r_err_pls <= w_mis;
            if (w_arm) begin
                r_idx       <= '0;
                r_err_flag  <= 1'b0;
                r_err_cnt   <= '0;
                r_first_idx <= '0;
                r_first_dat <= '0;
            end else if (w_beat) begin
                r_idx <= r_idx + 16'd1;
                if (w_mis) begin
                    r_err_flag <= 1'b1;
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
                    // flag still clear means this is the run's first mismatch
                    if (!r_err_flag) begin
                        r_first_idx <= r_idx;
                        r_first_dat <= din;
                    end
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign err_pls       = r_err_pls;
    assign err_flag      = r_err_flag;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_idx;
    assign first_err_dat = r_first_dat;

endmodule

// File: tb/tb_sdram_rd_chk.sv
// Bench for sdram_rd_chk: two instances (a: BURST_LEN=100, ERR_W=16;
// b: BURST_LEN=200, ERR_W=3 for wrap and saturation), directed test-plan
// runs plus randomized runs, all compared every cycle to a run-level model.
module tb_sdram_rd_chk;

    localparam int DW = 8;
    localparam int ST = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st[2];
    logic       vl[2];
    logic [7:0] dn[2];

    logic        o_busy[2], o_pls[2], o_flag[2], o_done[2];
    logic [15:0] o_cnt0;
    logic [2:0]  o_cnt1;
    logic [15:0] o_fidx[2];
    logic [7:0]  o_fdat[2];

    sdram_rd_chk #(.DATA_W(DW), .STEP(ST), .BURST_LEN(100), .ERR_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .din_vld(vl[0]), .din(dn[0]),
        .busy(o_busy[0]), .err_pls(o_pls[0]), .err_flag(o_flag[0]), .err_cnt(o_cnt0),
        .first_err_idx(o_fidx[0]), .first_err_dat(o_fdat[0]), .done(o_done[0])
    );

    sdram_rd_chk #(.DATA_W(DW), .STEP(ST), .BURST_LEN(200), .ERR_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .din_vld(vl[1]), .din(dn[1]),
        .busy(o_busy[1]), .err_pls(o_pls[1]), .err_flag(o_flag[1]), .err_cnt(o_cnt1),
        .first_err_idx(o_fidx[1]), .first_err_dat(o_fdat[1]), .done(o_done[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model: run phase 0=idle, 1=running, 2=finishing ----
    int  bl[2]   = '{100, 200};
    int  cmax[2] = '{65535, 7};
    int  m_ph[2], m_idx[2], m_exp[2], m_cnt[2], m_fidx[2], m_fdat[2];
    bit  m_flag[2], m_pls[2], m_done[2];
    int  n_done[2];

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_idx[k] = 0; m_exp[k] = 0; m_cnt[k] = 0;
            m_fidx[k] = 0; m_fdat[k] = 0; m_flag[k] = 0; m_pls[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic mstep(input int k);
        int base;
        m_pls[k]  = 0;
        m_done[k] = 0;
        if (m_ph[k] == 0) begin
            if (st[k]) begin
                m_ph[k] = 1; m_idx[k] = 0; m_exp[k] = 0; m_cnt[k] = 0;
                m_flag[k] = 0; m_fidx[k] = 0; m_fdat[k] = 0;
            end
        end else if (m_ph[k] == 1) begin
            if (vl[k]) begin
                base = m_exp[k];
                if (int'(dn[k]) != m_exp[k]) begin
                    m_pls[k] = 1;
                    if (!m_flag[k]) begin
                        m_fidx[k] = m_idx[k];
                        m_fdat[k] = int'(dn[k]);
                    end
                    m_flag[k] = 1;
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
`ifdef SDRAM_RD_CHK_RESYNC_EN
                    base = int'(dn[k]);
`endif
                end
                m_exp[k] = (base + ST) % 256;
                m_idx[k]++;
                if (m_idx[k] == bl[k]) begin
                    m_ph[k]   = 2;
                    m_done[k] = 1;
                end
            end
        end else begin
            m_ph[k] = 0;
        end
    endtask

    task automatic check_all(input int k);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".busy"},  32'(o_busy[k]), 32'(m_ph[k] == 1));
        chk({p, ".pls"},   32'(o_pls[k]),  32'(m_pls[k]));
        chk({p, ".flag"},  32'(o_flag[k]), 32'(m_flag[k]));
        chk({p, ".cnt"},   (k == 0) ? 32'(o_cnt0) : 32'(o_cnt1), 32'(m_cnt[k]));
        chk({p, ".fidx"},  32'(o_fidx[k]), 32'(m_fidx[k]));
        chk({p, ".fdat"},  32'(o_fdat[k]), 32'(m_fdat[k]));
        chk({p, ".done"},  32'(o_done[k]), 32'(m_done[k]));
    endtask

    // one clock: model consumes the inputs the DUT sampled, then compare
    task automatic tick();
        @(posedge clk);
        if (!rst_n) mreset();
        else begin
            mstep(0);
            mstep(1);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check_all(k);
            if (o_done[k]) n_done[k]++;
        end
    endtask

    task automatic drive(input int k, input logic s, input logic v, input logic [7:0] d);
        st[k] = s; vl[k] = v; dn[k] = d;
        tick();
        st[k] = 1'b0; vl[k] = 1'b0; dn[k] = 8'h00;
    endtask

    function automatic logic [7:0] pat(input int i);
        logic [7:0] v;
        v = 8'((i * ST) % 256);
        return v;
    endfunction

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b0, 8'h00);
    endtask

    // drop: skip pattern value at beat 10; corr: corrupt beat 5; gap: 1/0 valid
    task automatic run_dir(input int k, input int n, input bit corr, input bit drop,
                           input bit gap, input bit all_bad);
        int v;
        n_done[k] = 0;
        drive(k, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            v = (drop && i >= 10) ? i + 1 : i;
            if (all_bad)              drive(k, 1'b0, 1'b1, 8'hFF);
            else if (corr && i == 5)  drive(k, 1'b0, 1'b1, 8'hFF);
            else                      drive(k, 1'b0, 1'b1, pat(v));
            if (corr && i == 5) chk("corr.pls_next_cycle", 32'(o_pls[k]), 32'd1);
            if (i == n - 1)     chk("done_after_last", 32'(o_done[k]), 32'd1);
            if (gap && i != n - 1) drive(k, 1'b0, 1'b0, 8'h55);
        end
        idle(k, 2);
        chk("done_once", 32'(n_done[k]), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; vl[k] = 1'b0; dn[k] = 8'h00; n_done[k] = 0;
        end
        mreset();
        #2;
        for (int k = 0; k < 2; k++) check_all(k);   // reset values
        @(negedge clk); rst_n = 1'b1;
        idle(0, 2);

        // clean run
        run_dir(0, 100, 0, 0, 0, 0);
        chk("clean.cnt", 32'(o_cnt0), 32'd0);
        chk("clean.flag", 32'(o_flag[0]), 32'd0);

        // wrap 254 -> 0 on the 200-beat instance
        run_dir(1, 200, 0, 0, 0, 0);
        chk("wrap.cnt", 32'(o_cnt1), 32'd0);

        // single corruption at beat 5
        run_dir(0, 100, 1, 0, 0, 0);
        chk("corr.cnt", 32'(o_cnt0), 32'd1);
        chk("corr.fidx", 32'(o_fidx[0]), 32'd5);
        chk("corr.fdat", 32'(o_fdat[0]), 32'hFF);

        // dropped beat
        run_dir(0, 100, 0, 1, 0, 0);
`ifdef SDRAM_RD_CHK_RESYNC_EN
        chk("drop.cnt", 32'(o_cnt0), 32'd1);
`else
        chk("drop.cnt", 32'(o_cnt0), 32'd90);
`endif
        chk("drop.fidx", 32'(o_fidx[0]), 32'd10);

        // gapped valid gives the same result as back-to-back corruption run
        run_dir(0, 100, 1, 0, 1, 0);
        chk("gap.cnt", 32'(o_cnt0), 32'd1);
        chk("gap.fidx", 32'(o_fidx[0]), 32'd5);

        // beats in IDLE are ignored; results hold
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 1'b1, 8'hF1);
        chk("idle.cnt", 32'(o_cnt0), 32'd1);

        // saturation on the 3-bit counter
        run_dir(1, 200, 0, 0, 0, 1);
        chk("sat.cnt", 32'(o_cnt1), 32'd7);
        chk("sat.fidx", 32'(o_fidx[1]), 32'd0);

        // start with valid in same idle cycle, then second start mid-run
        n_done[0] = 0;
        drive(0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 100; i++) drive(0, (i == 30), 1'b1, pat(i));
        idle(0, 2);
        chk("restart.cnt", 32'(o_cnt0), 32'd0);
        chk("restart.done_once", 32'(n_done[0]), 32'd1);

        // reset mid-run after beat 40
        n_done[0] = 0;
        drive(0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i <= 40; i++) drive(0, 1'b0, 1'b1, (i == 3) ? 8'h07 : pat(i));
        rst_n = 1'b0;
        #1;
        mreset();
        check_all(0);
        chk("rst.busy", 32'(o_busy[0]), 32'd0);
        idle(0, 2);
        @(negedge clk); rst_n = 1'b1;
        idle(0, 2);
        chk("rst.no_done", 32'(n_done[0]), 32'd0);
        run_dir(0, 100, 0, 0, 0, 0);
        chk("rst.rerun.cnt", 32'(o_cnt0), 32'd0);

        // randomized runs: gaps, corruption, slips, ignored starts
        for (int r = 0; r < 16; r++) begin
            int k, p, budget;
            k = int'($urandom_range(1, 0));
            p = 0;
            budget = 0;
            drive(k, 1'b1, 1'b0, 8'h00);
            while (m_ph[k] == 1 && budget < 2000) begin
                logic [7:0] d;
                logic s, v;
                budget++;
                s = ($urandom_range(19, 0) == 0);
                v = ($urandom_range(3, 0) != 0);
                d = pat(p);
                if (v) begin
                    case ($urandom_range(39, 0))
                        0: p = p + 2;                       // drop
                        1: p = p;                           // duplicate
                        default: p = p + 1;
                    endcase
                    if ($urandom_range(15, 0) == 0) d = 8'($urandom);
                end
                drive(k, s, v, d);
            end
            if (budget >= 2000) chk("rand.timeout", 32'd1, 32'd0);
            idle(k, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
